mem_stage: RTL
==============

// Module: mem_stage
// PURPOSE
//  MEM pipeline stage of the 5-stage MIPS core. Sits between EX and WB, and feeds WB.
//  It registers the EX->MS bus and takes the data-SRAM read word for loads.
//  Load data is aligned and extended (lw/lb/lbu/lh/lhu), then forwarded to WB as a 70-bit bus.
//  It also drives a forwarding bus to ID and holds the SRAM word while WB back-pressures.
// PARAMETERS
//  ES_TO_MS_BUS_WD  74  EX->MS bus width
//  MS_TO_WS_BUS_WD  70  MS->WB bus width
//  MS_TO_DS_BUS_WD  39  MS->ID forwarding bus width
// PORTS
//  clk              in   1   clock, all state updates on rising edge
//  resetn           in   1   synchronous, active-low reset
//  ws_allowin       in   1   WB can accept an instruction this cycle
//  ms_allowin       out  1   MEM can accept an instruction this cycle
//  es_to_ms_valid   in   1   EX presents a valid instruction
//  es_to_ms_bus     in   74  {ld_type[2:0] 73:71, res_from_mem 70, gr_we 69, dest 68:64, alu_result 63:32, pc 31:0}
//  ms_to_ws_valid   out  1   valid toward WB
//  ms_to_ws_bus     out  70  {gr_we 69, dest 68:64, final_result 63:32, pc 31:0}
//  ms_to_ds_bus     out  39  {ms_valid 38, fwd_we 37, dest 36:32, final_result 31:0}
//  data_sram_rdata  in   32  SRAM read word; valid only in the cycle after EX issued the read
// BEHAVIOUR
//  - Reset (resetn=0 at clk edge): ms_valid=0, first=0, buf_valid=0.
//    Outputs: ms_to_ws_valid=0, ms_to_ds_bus[38]=0, ms_allowin=1.
//    The bus register and data buffer are don't-care.
//  - Handshake: ms_ready_go=1; ms_allowin = !ms_valid || (ms_ready_go && ws_allowin).
//    ms_to_ws_valid = ms_valid && ms_ready_go.
//    If ms_allowin=1: ms_valid <= es_to_ms_valid.
//    If es_to_ms_valid && ms_allowin: capture the bus, set first<=1, clear buf_valid.
//    Otherwise first<=0.
//  - Data-hold FSM, one state per instruction: FIRST -> HELD.
//    FIRST: the cycle right after capture. The load word comes from data_sram_rdata.
//    If ms_valid && first && !ws_allowin: rdata_buf <= data_sram_rdata, buf_valid <= 1 (enter HELD).
//    HELD: the load word comes from rdata_buf. Later SRAM rdata changes are ignored.
//    The instruction leaves at the cycle it advances. A new capture clears buf_valid.
//  - The word source is the same in both states: load_word = buf_valid ? rdata_buf : data_sram_rdata.
//  - Alignment: a = alu_result[1:0]. The selected byte is load_word[8a+7:8a].
//    The selected half is load_word[31:16] if a[1], else [15:0]. a[0] is ignored for halves.
//  - ld_type encoding:
//    - 0: lw, the whole word
//    - 1: lb, byte sign-extended
//    - 2: lbu, byte zero-extended
//    - 3: lh, half sign-extended
//    - 4: lhu, half zero-extended
//    - 5-7: treated as lw
//  - final_result = res_from_mem ? extended load data : alu_result.
//    ms_to_ws_bus passes gr_we, dest and pc unchanged.
//  - Forwarding: fwd_we = gr_we && ms_valid.
//    ms_to_ds_bus carries the same final_result, valid for loads as well.
//  - Simultaneous advance and capture: in the same edge the old instruction leaves and the new one loads.
//    The new one has first=1 and buf_valid=0.
//  - Reset during HELD or FIRST: the instruction is dropped. No output is valid the next cycle.
// TESTING
//  1 lw: alu_result=0x100, rdata=0x12345678, ws_allowin=1.
//    -> ms_to_ws_valid=1 for 1 cycle, final_result=0x12345678.
//  2 lb addr low=3, rdata=0x80AABBCC -> final_result=0xFFFFFF80.
//    lbu with the same inputs -> 0x00000080.
//  3 lh addr low=2, rdata=0x8001_7FFF -> final_result=0xFFFF8001.
//    lhu addr low=0 -> 0x00007FFF.
//  4 lw with rdata=0xCAFEF00D, then ws_allowin=0 for 3 cycles while rdata=0xDEADBEEF.
//    -> ms_to_ws_valid held at 1, final_result stays 0xCAFEF00D, ms_allowin=0.
//    -> retires on the cycle ws_allowin=1.
//  5 back-to-back addu (alu_result=7, gr_we=1, dest=5) then lw.
//    -> consecutive ms_to_ws_valid cycles.
//    -> ms_to_ds_bus={1,1,5,7} then the load data.
//  6 resetn=0 for 1 cycle while in HELD -> next cycle ms_to_ws_valid=0, ms_to_ds_bus[38]=0, ms_allowin=1.

Source files
------------

// File: rtl/mem_stage.sv
// MEM stage of the 5-stage MIPS pipeline: registers the EX->MS bus, aligns and extends load data,
// and keeps the SRAM read word in a buffer while WB back-pressures so the word is not lost.
module mem_stage #(
   parameter int unsigned ES_TO_MS_BUS_WD = 74,
   parameter int unsigned MS_TO_WS_BUS_WD = 70,
   parameter int unsigned MS_TO_DS_BUS_WD = 39
) (
   input  logic                       clk,
   input  logic                       resetn,
   input  logic                       ws_allowin,
   output logic                       ms_allowin,
   input  logic                       es_to_ms_valid,
   input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
   output logic                       ms_to_ws_valid,
   output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
   output logic [MS_TO_DS_BUS_WD-1:0] ms_to_ds_bus,
   input  logic [31:0]                data_sram_rdata
);

   typedef enum logic [1:0] {
      StIdle,
      StFirst,
      StHeld
   } hold_state_e;

   localparam logic [2:0] LdLw  = 3'd0;
   localparam logic [2:0] LdLb  = 3'd1;
   localparam logic [2:0] LdLbu = 3'd2;
   localparam logic [2:0] LdLh  = 3'd3;
   localparam logic [2:0] LdLhu = 3'd4;

   hold_state_e                hold_q, hold_d;
   logic                       ms_valid;
   logic                       ms_ready_go;
   logic                       capture;
   logic                       first;
   logic                       buf_valid;
   logic                       buf_load;
   logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus_r;
   logic [31:0]                rdata_buf;

   logic [2:0]  ld_type;
   logic        res_from_mem;
   logic        gr_we;
   logic [4:0]  dest;
   logic [31:0] alu_result;
   logic [31:0] pc;
   logic [1:0]  addr_low;

   logic [31:0] load_word;
   logic [7:0]  load_byte;
   logic [15:0] load_half;
   logic [31:0] mem_result;
   logic [31:0] final_result;
   logic        fwd_we;

   assign {ld_type, res_from_mem, gr_we, dest, alu_result, pc} = es_to_ms_bus_r;
   assign addr_low = alu_result[1:0];

   // Handshake; MEM never stalls on its own.
   assign ms_ready_go    = 1'b1;
   assign ms_allowin     = !ms_valid || (ms_ready_go && ws_allowin);
   assign ms_to_ws_valid = ms_valid && ms_ready_go;
   assign capture        = es_to_ms_valid && ms_allowin;

   assign first     = (hold_q == StFirst);
   assign buf_valid = (hold_q == StHeld);

   always_ff @(posedge clk) begin
      if (!resetn) begin
         ms_valid <= 1'b0;
         hold_q   <= StIdle;
      end else begin
         if (ms_allowin) begin
            ms_valid <= es_to_ms_valid;
         end
         hold_q <= hold_d;
      end
   end

   always_ff @(posedge clk) begin
      if (capture) begin
         es_to_ms_bus_r <= es_to_ms_bus;
      end
      if (buf_load) begin
         rdata_buf <= data_sram_rdata;
      end
   end

   // The SRAM word is only valid in the first cycle; snapshot it if WB is not ready then.
   always_comb begin
      hold_d   = hold_q;
      buf_load = 1'b0;
      if (capture) begin
         hold_d = StFirst;
      end else begin
         unique case (hold_q)
            StFirst: begin
               if (ms_valid && first && !ws_allowin) begin
                  hold_d   = StHeld;
                  buf_load = 1'b1;
               end else begin
                  hold_d = StIdle;
               end
            end
            StHeld:  hold_d = StHeld;
            default: hold_d = StIdle;
         endcase
      end
   end

   assign load_word = buf_valid ? rdata_buf : data_sram_rdata;

   always_comb begin
      load_byte = 8'h00;
      unique case (addr_low)
         2'd0: load_byte = load_word[7:0];
         2'd1: load_byte = load_word[15:8];
         2'd2: load_byte = load_word[23:16];
         2'd3: load_byte = load_word[31:24];
         default: load_byte = 8'h00;
      endcase
   end

   assign load_half = addr_low[1] ? load_word[31:16] : load_word[15:0];

   always_comb begin
      mem_result = load_word;
      unique case (ld_type)
         LdLw:    mem_result = load_word;
         LdLb:    mem_result = {{24{load_byte[7]}}, load_byte};
         LdLbu:   mem_result = {24'h000000, load_byte};
         LdLh:    mem_result = {{16{load_half[15]}}, load_half};
         LdLhu:   mem_result = {16'h0000, load_half};
         default: mem_result = load_word;
      endcase
   end

   assign final_result = res_from_mem ? mem_result : alu_result;
   assign fwd_we       = gr_we && ms_valid;

   assign ms_to_ws_bus = {gr_we, dest, final_result, pc};
   assign ms_to_ds_bus = {ms_valid, fwd_we, dest, final_result};

endmodule
